psram_wb_arbiter: RTL and testbench

//  Two-master Wishbone arbiter sharing one EF_PSRAM_CTRL_wb slave port, e.g. an instruction-fetch

---
 rtl/psram_wb_arbiter.sv | 176 +++++++++++++++++
 tb/tb_psram_wb_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_wb_arbiter.sv
// psram_wb_arbiter: two Wishbone masters sharing one PSRAM controller slave port.
// Round-robin or fixed m0 priority, the bus stays locked to the owner while its
// cyc_i is high, and an ack watchdog ends a hung PSRAM access with err.
// The watchdog counter width TW must satisfy 2**TW > TIMEOUT.
module psram_wb_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int PRIO_M0 = 0,
   parameter int TIMEOUT = 256,
   parameter int TW      = 9
) (
   input  logic            clk_i,
   input  logic            rst_i,
   // master 0
   input  logic            m0_cyc_i,
   input  logic            m0_stb_i,
   input  logic            m0_we_i,
   input  logic [AW-1:0]   m0_adr_i,
   input  logic [DW-1:0]   m0_dat_i,
   input  logic [DW/8-1:0] m0_sel_i,
   output logic [DW-1:0]   m0_dat_o,
   output logic            m0_ack_o,
   output logic            m0_err_o,
   // master 1
   input  logic            m1_cyc_i,
   input  logic            m1_stb_i,
   input  logic            m1_we_i,
   input  logic [AW-1:0]   m1_adr_i,
   input  logic [DW-1:0]   m1_dat_i,
   input  logic [DW/8-1:0] m1_sel_i,
   output logic [DW-1:0]   m1_dat_o,
   output logic            m1_ack_o,
   output logic            m1_err_o,
   // shared slave port
   output logic            s_cyc_o,
   output logic            s_stb_o,
   output logic            s_we_o,
   output logic [AW-1:0]   s_adr_o,
   output logic [DW-1:0]   s_dat_o,
   output logic [DW/8-1:0] s_sel_o,
   input  logic [DW-1:0]   s_dat_i,
   input  logic            s_ack_i,
   // status
   output logic            busy_o,
   output logic            owner_o
);

   localparam int SW = DW / 8;

   // Last watchdog count before abort; unused (and forced to zero) when disabled.
   localparam logic [TW-1:0] WDOG_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_ABORT = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic            owner_reg, owner_next;
   logic [TW-1:0]   wdog_reg, wdog_next;

   // Master inputs gathered into index-able arrays so the owner mux is a plain select.
   logic [1:0]      m_cyc, m_stb, m_we, req;
   logic [AW-1:0]   m_adr [2];
   logic [DW-1:0]   m_dat [2];
   logic [SW-1:0]   m_sel [2];

   assign m_cyc    = {m1_cyc_i, m0_cyc_i};
   assign m_stb    = {m1_stb_i, m0_stb_i};
   assign m_we     = {m1_we_i,  m0_we_i};
   assign m_adr[0] = m0_adr_i;
   assign m_adr[1] = m1_adr_i;
   assign m_dat[0] = m0_dat_i;
   assign m_dat[1] = m1_dat_i;
   assign m_sel[0] = m0_sel_i;
   assign m_sel[1] = m1_sel_i;
   assign req      = m_cyc & m_stb;

   logic in_busy, own_cyc, own_stb, xfer_ack, wdog_hit;

   assign in_busy = (state_reg == ST_BUSY);
   assign own_cyc = m_cyc[owner_reg];
   assign own_stb = m_stb[owner_reg];

   // Slave side follows the owner only while BUSY; IDLE and ABORT present an idle bus.
   assign s_cyc_o = in_busy & own_cyc;
   assign s_stb_o = in_busy & own_cyc & own_stb;
   assign s_we_o  = in_busy & m_we[owner_reg];
   assign s_adr_o = in_busy ? m_adr[owner_reg] : '0;
   assign s_dat_o = in_busy ? m_dat[owner_reg] : '0;
   assign s_sel_o = in_busy ? m_sel[owner_reg] : '0;

   // An ack only counts against a live strobe, so late acks in IDLE/ABORT vanish here.
   assign xfer_ack = s_stb_o & s_ack_i;

   // Timeout fires on the last allowed waiting cycle; an ack on that same cycle wins.
   assign wdog_hit = (TIMEOUT != 0) && s_stb_o && !s_ack_i && (wdog_reg == WDOG_LAST);

   // Per-master return path: ack/err steered to the owner, read data broadcast.
   logic [1:0]    ack_vec, err_vec;
   logic [DW-1:0] rdat_vec [2];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_master
         assign ack_vec[gi]  = xfer_ack & (owner_reg == 1'(gi)) & m_stb[gi];
         assign err_vec[gi]  = wdog_hit & (owner_reg == 1'(gi));
         // Read data is held at zero while reset is asserted.
         assign rdat_vec[gi] = rst_i ? s_dat_i : '0;
      end
   endgenerate

   assign m0_ack_o = ack_vec[0];
   assign m1_ack_o = ack_vec[1];
   assign m0_err_o = err_vec[0];
   assign m1_err_o = err_vec[1];
   assign m0_dat_o = rdat_vec[0];
   assign m1_dat_o = rdat_vec[1];

   assign busy_o  = (state_reg != ST_IDLE);
   assign owner_o = owner_reg;

   // State, owner and watchdog registers; owner resets to 1 so m0 wins the first tie.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg <= ST_IDLE;
         owner_reg <= 1'b1;
         wdog_reg  <= '0;
      end else begin
         state_reg <= state_next;
         owner_reg <= owner_next;
         wdog_reg  <= wdog_next;
      end
   end

   // Grant decision, bus-lock release, watchdog counting and abort handling.
   always_comb begin
      state_next = state_reg;
      owner_next = owner_reg;
      wdog_next  = '0;
      unique case (state_reg)
         ST_IDLE: begin
            if (req != 2'b00) begin
               state_next = ST_BUSY;
               if (req == 2'b11) begin
                  // Tie: fixed priority to m0, otherwise whoever did not own last.
                  owner_next = (PRIO_M0 != 0) ? 1'b0 : ~owner_reg;
               end else begin
                  owner_next = req[1];
               end
            end
         end
         ST_BUSY: begin
            if (!own_cyc) begin
               // Owner released the bus (normally or mid-transfer).
               state_next = ST_IDLE;
            end else if (wdog_hit) begin
               state_next = ST_ABORT;
            end else if ((TIMEOUT != 0) && s_stb_o && !s_ack_i) begin
               wdog_next = wdog_reg + 1'b1;
            end
         end
         ST_ABORT: begin
            // Slave is ignored; wait for the owner to give up the cycle.
            if (!own_cyc) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_psram_wb_arbiter.sv
// Directed bench for psram_wb_arbiter. Instance A (round-robin, TIMEOUT=16) and
// instance B (m0 priority, TIMEOUT=16) share the master stimulus; each has its own
// behavioural memory slave that acks one cycle after a strobe is seen.
module tb_psram_wb_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // shared master stimulus
   logic        m_cyc [2];
   logic        m_stb [2];
   logic        m_we  [2];
   logic [31:0] m_adr [2];
   logic [31:0] m_dat [2];
   logic [3:0]  m_sel [2];

   // instance A signals
   logic [31:0] a_rdat [2];
   logic        a_ack  [2];
   logic        a_err  [2];
   logic        a_s_cyc, a_s_stb, a_s_we, a_s_ack, a_busy, a_owner;
   logic [31:0] a_s_adr, a_s_dat, a_s_rdat;
   logic [3:0]  a_s_sel;

   // instance B signals
   logic [31:0] b_rdat [2];
   logic        b_ack  [2];
   logic        b_err  [2];
   logic        b_s_cyc, b_s_stb, b_s_we, b_s_ack, b_busy, b_owner;
   logic [31:0] b_s_adr, b_s_dat, b_s_rdat;
   logic [3:0]  b_s_sel;

   psram_wb_arbiter #(.AW(32), .DW(32), .PRIO_M0(0), .TIMEOUT(16), .TW(5)) dut_a (
      .clk_i(clk), .rst_i(rst),
      .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]),
      .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]),
      .m0_dat_o(a_rdat[0]), .m0_ack_o(a_ack[0]), .m0_err_o(a_err[0]),
      .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]),
      .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]),
      .m1_dat_o(a_rdat[1]), .m1_ack_o(a_ack[1]), .m1_err_o(a_err[1]),
      .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_we_o(a_s_we),
      .s_adr_o(a_s_adr), .s_dat_o(a_s_dat), .s_sel_o(a_s_sel),
      .s_dat_i(a_s_rdat), .s_ack_i(a_s_ack),
      .busy_o(a_busy), .owner_o(a_owner)
   );

   psram_wb_arbiter #(.AW(32), .DW(32), .PRIO_M0(1), .TIMEOUT(16), .TW(5)) dut_b (
      .clk_i(clk), .rst_i(rst),
      .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]),
      .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]),
      .m0_dat_o(b_rdat[0]), .m0_ack_o(b_ack[0]), .m0_err_o(b_err[0]),
      .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]),
      .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]),
      .m1_dat_o(b_rdat[1]), .m1_ack_o(b_ack[1]), .m1_err_o(b_err[1]),
      .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we),
      .s_adr_o(b_s_adr), .s_dat_o(b_s_dat), .s_sel_o(b_s_sel),
      .s_dat_i(b_s_rdat), .s_ack_i(b_s_ack),
      .busy_o(b_busy), .owner_o(b_owner)
   );

   // ---------------- slave models ----------------
   logic [31:0] a_mem [64];
   logic [31:0] b_mem [64];
   logic        a_ack_reg = 1'b0;
   logic        b_ack_reg = 1'b0;
   logic        ack_en    = 1'b1;
   logic        inject    = 1'b0;

   assign a_s_rdat = a_mem[a_s_adr[7:2]];
   assign b_s_rdat = b_mem[b_s_adr[7:2]];
   assign a_s_ack  = a_ack_reg | inject;
   assign b_s_ack  = b_ack_reg;

   // slave A: acks one cycle after a strobe when enabled; preloads word 0 during reset
   always @(posedge clk) begin
      if (!rst) a_mem[0] <= 32'h5A5A_5A5A;
      if (a_s_cyc && a_s_stb && !a_ack_reg && ack_en) begin
         a_ack_reg <= 1'b1;
         if (a_s_we) a_mem[a_s_adr[7:2]] <= a_s_dat;
      end else begin
         a_ack_reg <= 1'b0;
      end
   end

   // slave B: always acks one cycle after a strobe
   always @(posedge clk) begin
      if (b_s_cyc && b_s_stb && !b_ack_reg) begin
         b_ack_reg <= 1'b1;
         if (b_s_we) b_mem[b_s_adr[7:2]] <= b_s_dat;
      end else begin
         b_ack_reg <= 1'b0;
      end
   end

   // ack pulse counters for instance A, sampled away from the active edge
   int a_ack_cnt0 = 0;
   int a_ack_cnt1 = 0;
   always @(negedge clk) begin
      if (a_ack[0] === 1'b1) a_ack_cnt0 <= a_ack_cnt0 + 1;
      if (a_ack[1] === 1'b1) a_ack_cnt1 <= a_ack_cnt1 + 1;
   end

   logic [31:0] last_sadr;

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic ack_of(input bit use_b, input int m);
      return use_b ? b_ack[m] : a_ack[m];
   endfunction

   task automatic idle_m(input int m);
      m_cyc[m] = 1'b0;
      m_stb[m] = 1'b0;
      m_we[m]  = 1'b0;
   endtask

   // One transfer on instance A by master m; cyc is kept when drop=0.
   task automatic xfer(input int m, input bit we, input logic [31:0] adr,
                       input logic [31:0] wdat, input bit drop, output logic [31:0] rdat);
      int n;
      bit got;
      m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we;
      m_adr[m] = adr;  m_dat[m] = wdat; m_sel[m] = 4'hF;
      #1;
      n = 0; got = 1'b0;
      while (!got && n < 40) begin
         if (a_ack[m] === 1'b1) got = 1'b1;
         else begin step(); n++; end
      end
      chk("ack_wait", 32'(got), 32'd1);
      rdat      = a_rdat[m];
      last_sadr = a_s_adr;
      step();
      chk("ack_one_pulse", 32'(a_ack[m]), 32'd0);
      m_stb[m] = 1'b0;
      if (drop) m_cyc[m] = 1'b0;
   endtask

   // Both masters read continuously; each winner drops cyc after one read, then
   // re-requests (except after the last round). Checks grant order and the IDLE gap.
   task automatic contend(input int n, input bit use_b);
      for (int m = 0; m < 2; m++) begin
         m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = 1'b0;
         m_adr[m] = 32'(m * 4); m_sel[m] = 4'hF;
      end
      #1;
      for (int i = 0; i < n; i++) begin
         int k;
         int exp_w;
         int got;
         logic a0, a1;
         exp_w = use_b ? 0 : (i % 2);
         k = 0;
         a0 = ack_of(use_b, 0); a1 = ack_of(use_b, 1);
         while (!(a0 === 1'b1 || a1 === 1'b1) && k < 40) begin
            step(); k++;
            a0 = ack_of(use_b, 0); a1 = ack_of(use_b, 1);
         end
         chk("grant_wait", 32'(a0 | a1), 32'd1);
         got = (a1 === 1'b1) ? 1 : 0;
         $display("round %0d: grant m%0d (expect m%0d) owner=%0d", i, got, exp_w,
                  use_b ? b_owner : a_owner);
         chk("grant_idx", 32'(got), 32'(exp_w));
         chk("owner_track", 32'(use_b ? b_owner : a_owner), 32'(exp_w));
         chk("ack_excl", 32'(a0 & a1), 32'd0);
         step();
         m_cyc[got] = 1'b0; m_stb[got] = 1'b0;
         #1;
         chk("release_scyc", 32'(use_b ? b_s_cyc : a_s_cyc), 32'd0);
         step();
         chk("idle_gap", 32'(use_b ? b_busy : a_busy), 32'd0);
         if (i < n - 1) begin
            m_cyc[got] = 1'b1; m_stb[got] = 1'b1;
         end
      end
   endtask

   // global guard against a hang
   initial begin
      #400000;
      $display("FAIL global_timeout reached");
      $fatal(1);
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic [31:0] rd;
      int c0;
      int cnt;
      int first_err;
      for (int m = 0; m < 2; m++) begin
         idle_m(m);
         m_adr[m] = '0; m_dat[m] = '0; m_sel[m] = 4'hF;
      end
      rst = 1'b0;
      repeat (3) step();

      // reset state
      $display("reset: owner=%0d busy=%0d s_cyc=%0d", a_owner, a_busy, a_s_cyc);
      chk("rst_owner", 32'(a_owner), 32'd1);
      chk("rst_owner_b", 32'(b_owner), 32'd1);
      chk("rst_busy", 32'(a_busy), 32'd0);
      chk("rst_scyc", 32'(a_s_cyc), 32'd0);
      chk("rst_sstb", 32'(a_s_stb), 32'd0);
      chk("rst_ack0", 32'(a_ack[0]), 32'd0);
      chk("rst_err1", 32'(a_err[1]), 32'd0);
      chk("rst_dat0", a_rdat[0], 32'd0);
      rst = 1'b1;
      step();

      // 1: m0 write then read at address 0
      xfer(0, 1'b1, 32'h0, 32'hABCD_1234, 1'b1, rd);
      $display("t1 write: s_adr=%h owner=%0d", last_sadr, a_owner);
      chk("t1_wr_sadr", last_sadr, 32'h0);
      chk("t1_owner", 32'(a_owner), 32'd0);
      step();
      xfer(0, 1'b0, 32'h0, 32'h0, 1'b1, rd);
      $display("t1 read: data=%h", rd);
      chk("t1_rdata", rd, 32'hABCD_1234);
      chk("t1_rd_sadr", last_sadr, 32'h0);
      step();
      chk("t1_m1_noack", 32'(a_ack_cnt1), 32'd0);
      chk("t1_m0_acks", 32'(a_ack_cnt0), 32'd2);

      // 2: round-robin alternation straight out of reset
      rst = 1'b0; step(); rst = 1'b1; step();
      contend(6, 1'b0);
      idle_m(0); idle_m(1);
      repeat (4) step();
      chk("t2_final_idle", 32'(a_busy), 32'd0);

      // 3: m1 holds the bus over two writes while m0 waits to read
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
      m_adr[1] = 32'h10; m_dat[1] = 32'h1111_1111;
      step();
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 32'h10;
      c0 = a_ack_cnt0;
      xfer(1, 1'b1, 32'h10, 32'h1111_1111, 1'b0, rd);
      chk("t3_locked_owner", 32'(a_owner), 32'd1);
      xfer(1, 1'b1, 32'h14, 32'h2222_2222, 1'b1, rd);
      $display("t3 m1 done: owner=%0d m0 acks during lock=%0d", a_owner, a_ack_cnt0 - c0);
      chk("t3_m0_waited", 32'(a_ack_cnt0), 32'(c0));
      xfer(0, 1'b0, 32'h10, 32'h0, 1'b0, rd);
      $display("t3 m0 read 0x10: data=%h", rd);
      chk("t3_rd10", rd, 32'h1111_1111);
      chk("t3_owner_m0", 32'(a_owner), 32'd0);
      xfer(0, 1'b0, 32'h14, 32'h0, 1'b1, rd);
      $display("t3 m0 read 0x14: data=%h", rd);
      chk("t3_rd14", rd, 32'h2222_2222);
      step(); step();

      // 4: watchdog abort with a slave that never acks
      ack_en = 1'b0;
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_adr[1] = 32'h20;
      #1;
      cnt = 0; first_err = 0;
      for (int k = 0; k < 40 && first_err == 0; k++) begin
         step();
         if (a_s_stb === 1'b1) cnt++;
         if (a_err[1] === 1'b1) first_err = cnt;
      end
      $display("t4 err on stb cycle %0d", first_err);
      chk("t4_err_cycle", 32'(first_err), 32'd16);
      chk("t4_no_ack", 32'(a_ack[1]), 32'd0);
      chk("t4_m0_no_err", 32'(a_err[0]), 32'd0);
      step();
      chk("t4_scyc_low", 32'(a_s_cyc), 32'd0);
      chk("t4_err_single", 32'(a_err[1]), 32'd0);
      chk("t4_abort_busy", 32'(a_busy), 32'd1);
      inject = 1'b1;
      #1;
      chk("t4_inject_noack", 32'(a_ack[1]), 32'd0);
      step();
      inject = 1'b0;
      chk("t4_abort_held", 32'(a_busy), 32'd1);
      idle_m(1);
      step();
      chk("t4_back_idle", 32'(a_busy), 32'd0);
      ack_en = 1'b1;
      step();

      // 5: asynchronous reset during a BUSY m0 read
      ack_en = 1'b0;
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 32'h0;
      step(); step();
      chk("t5_busy_before", 32'(a_busy), 32'd1);
      chk("t5_scyc_before", 32'(a_s_cyc), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      $display("t5 reset mid-busy: busy=%0d s_cyc=%0d owner=%0d", a_busy, a_s_cyc, a_owner);
      chk("t5_scyc", 32'(a_s_cyc), 32'd0);
      chk("t5_sstb", 32'(a_s_stb), 32'd0);
      chk("t5_sadr", a_s_adr, 32'd0);
      chk("t5_busy", 32'(a_busy), 32'd0);
      chk("t5_ack", 32'(a_ack[0]), 32'd0);
      chk("t5_err", 32'(a_err[0]), 32'd0);
      chk("t5_owner", 32'(a_owner), 32'd1);
      chk("t5_dat", a_rdat[0], 32'd0);
      step();
      rst = 1'b1;
      ack_en = 1'b1;
      contend(1, 1'b0);
      idle_m(0); idle_m(1);
      repeat (4) step();

      // 6: fixed priority on instance B
      rst = 1'b0; step(); rst = 1'b1; step();
      contend(4, 1'b1);
      begin
         int k;
         k = 0;
         while (b_ack[1] !== 1'b1 && b_ack[0] !== 1'b1 && k < 40) begin step(); k++; end
         $display("t6 after m0 idles: m1 ack=%0d m0 ack=%0d", b_ack[1], b_ack[0]);
         chk("t6_m1_granted", 32'(b_ack[1]), 32'd1);
         chk("t6_owner_m1", 32'(b_owner), 32'd1);
      end
      idle_m(0); idle_m(1);
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
